// File: rtl/q412_multiplier.sv
// Unsigned Q4.12 sequential shift-add multiplier: one multiplier bit per cycle,
// 32-bit exact accumulator, truncated Q4.12 result with saturation on overflow.
module q412_multiplier #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC_BITS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic             valid,
  output logic             error,
  output logic             busy
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned RES_HI = WIDTH + FRAC_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   product_q, product_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic               busy_q, busy_d;

  assign product = product_q;
  assign valid   = valid_q;
  assign error   = error_q;
  assign busy    = busy_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    valid_d   = 1'b0;
    error_d   = error_q;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = multiplicand;
          b_d       = multiplier;
          acc_d     = '0;
          cnt_d     = '0;
          product_d = '0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = CALC;
        end
      end

      CALC: begin
        // Zero operand is detected on the latched values before any bit is processed
        if ((cnt_q == '0) && ((a_q == '0) || (b_q == '0))) begin
          state_d = DONE;
        end else begin
          if (b_q[cnt_q[3:0]]) begin
            acc_d = acc_q + (ACC_W'(a_q) << cnt_q);
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (acc_q[ACC_W-1:RES_HI] != '0) begin
          product_d = '1;
          error_d   = 1'b1;
        end else begin
          product_d = acc_q[RES_HI-1:FRAC_BITS];
          error_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
